// File: rtl/rx_msg_fifo.sv
// rx_msg_fifo: receive-frame buffer between the CAN RX bit engine and the
// register MUX. Holds up to DEPTH complete frames (ID, DLC, DATA1, DATA2) and
// presents the head frame first-word-fall-through on four read buses. It also
// reports the fill level, full and almost-full flags, and counts frames that
// were dropped because no slot was free.
module rx_msg_fifo #(
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6,
  parameter int OVF_W     = 8
) (
  input  logic                     sys_clk,
  input  logic                     IP2Can_reset,
  input  logic                     rx_wr_en,
  input  logic [4*WORD_W-1:0]      rx_wr_msg,
  input  logic                     rx_rd_pop,
  input  logic                     ovf_clr,
  output logic [WORD_W-1:0]        rxfifo_id2MUX,
  output logic [WORD_W-1:0]        rxfifo_dlc2MUX,
  output logic [WORD_W-1:0]        rxfifo_dataword12MUX,
  output logic [WORD_W-1:0]        rxfifo_dataword22MUX,
  output logic                     rx_not_empty,
  output logic                     rx_full,
  output logic                     rx_afull,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     rx_overflow,
  output logic [OVF_W-1:0]         rx_ovf_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int FRAME_W = 4 * WORD_W;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_acc;
  logic               pop_acc;
  logic               drop;
  logic [FRAME_W-1:0] head;

  // Status flags decoded from the registered level, so they never glitch on inputs.
  assign rx_not_empty = (rx_level != '0);
  assign rx_full      = (rx_level == LVL_W'(DEPTH));
  assign rx_afull     = (rx_level >= LVL_W'(AFULL_LVL));

  // Accept/drop decisions; a pop frees the slot a same-cycle push into a full buffer needs.
  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    push_acc = rx_wr_en && (!rx_full || rx_rd_pop);
    pop_acc  = rx_rd_pop && rx_not_empty;
    drop     = rx_wr_en && !push_acc;
  end

  // Frame storage: written only on an accepted push.
  // NOTE: the memory is deliberately not reset; its contents are masked by rx_level
  // until written, and leaving it out of reset keeps it mappable to plain RAM.
  always_ff @(posedge sys_clk) begin
    if (push_acc && !IP2Can_reset) begin
      mem[wr_ptr] <= rx_wr_msg;
    end
  end

  // Pointers and fill level; pointers wrap naturally at DEPTH (a power of two).
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_level <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_acc, pop_acc})
        2'b10:   rx_level <= rx_level + LVL_W'(1);
        2'b01:   rx_level <= rx_level - LVL_W'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // Overflow accounting; a drop in the same cycle as a clear wins and counts as the first drop.
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      rx_overflow <= 1'b0;
      rx_ovf_cnt  <= '0;
    end else if (drop) begin
      rx_overflow <= 1'b1;
      if (ovf_clr) begin
        rx_ovf_cnt <= OVF_W'(1);
      end else if (rx_ovf_cnt != '1) begin
        rx_ovf_cnt <= rx_ovf_cnt + OVF_W'(1);
      end
    end else if (ovf_clr) begin
      rx_overflow <= 1'b0;
      rx_ovf_cnt  <= '0;
    end
  end

  // Head frame split onto the MUX buses; all zero while the buffer is empty.
  assign head = rx_not_empty ? mem[rd_ptr] : '0;
  assign rxfifo_id2MUX        = head[4*WORD_W-1:3*WORD_W];
  assign rxfifo_dlc2MUX       = head[3*WORD_W-1:2*WORD_W];
  assign rxfifo_dataword12MUX = head[2*WORD_W-1:WORD_W];
  assign rxfifo_dataword22MUX = head[WORD_W-1:0];

endmodule

// File: tb/tb_rx_msg_fifo.sv
// tb_rx_msg_fifo: directed scenarios plus randomized traffic for rx_msg_fifo,
// checked every cycle against a queue-based reference model.
module tb_rx_msg_fifo;

  localparam int WORD_W    = 32;
  localparam int DEPTH     = 8;
  localparam int AFULL_LVL = 6;
  localparam int OVF_W     = 8;
  localparam int OVF_MAX   = (1 << OVF_W) - 1;

  logic                   sys_clk = 1'b0;
  logic                   IP2Can_reset;
  logic                   rx_wr_en;
  logic [4*WORD_W-1:0]    rx_wr_msg;
  logic                   rx_rd_pop;
  logic                   ovf_clr;
  logic [WORD_W-1:0]      rxfifo_id2MUX;
  logic [WORD_W-1:0]      rxfifo_dlc2MUX;
  logic [WORD_W-1:0]      rxfifo_dataword12MUX;
  logic [WORD_W-1:0]      rxfifo_dataword22MUX;
  logic                   rx_not_empty;
  logic                   rx_full;
  logic                   rx_afull;
  logic [$clog2(DEPTH):0] rx_level;
  logic                   rx_overflow;
  logic [OVF_W-1:0]       rx_ovf_cnt;

  rx_msg_fifo #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .OVF_W(OVF_W)
  ) dut (
    .sys_clk(sys_clk),
    .IP2Can_reset(IP2Can_reset),
    .rx_wr_en(rx_wr_en),
    .rx_wr_msg(rx_wr_msg),
    .rx_rd_pop(rx_rd_pop),
    .ovf_clr(ovf_clr),
    .rxfifo_id2MUX(rxfifo_id2MUX),
    .rxfifo_dlc2MUX(rxfifo_dlc2MUX),
    .rxfifo_dataword12MUX(rxfifo_dataword12MUX),
    .rxfifo_dataword22MUX(rxfifo_dataword22MUX),
    .rx_not_empty(rx_not_empty),
    .rx_full(rx_full),
    .rx_afull(rx_afull),
    .rx_level(rx_level),
    .rx_overflow(rx_overflow),
    .rx_ovf_cnt(rx_ovf_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state
  logic [4*WORD_W-1:0] model_q [$];
  bit                  model_ovf;
  int                  model_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] id, input logic [31:0] dlc,
                                      input logic [31:0] d1, input logic [31:0] d2);
    return {id, dlc, d1, d2};
  endfunction

  // Model of one clock edge, from the behavioural rules of the buffer.
  task automatic model_edge(input bit wr, input logic [127:0] msg, input bit pop,
                            input bit clr, input bit rst);
    bit full, push_ok, pop_ok, dropped;
    full    = (model_q.size() == DEPTH);
    push_ok = wr && (!full || pop);
    pop_ok  = pop && (model_q.size() > 0);
    dropped = wr && !push_ok;
    if (rst) begin
      model_q.delete();
      model_ovf = 0;
      model_cnt = 0;
      return;
    end
    if (pop_ok)  void'(model_q.pop_front());
    if (push_ok) model_q.push_back(msg);
    if (dropped) begin
      model_ovf = 1;
      model_cnt = clr ? 1 : ((model_cnt < OVF_MAX) ? model_cnt + 1 : OVF_MAX);
    end else if (clr) begin
      model_ovf = 0;
      model_cnt = 0;
    end
  endtask

  task automatic compare_all();
    logic [127:0] exp;
    int lvl;
    lvl = model_q.size();
    exp = (lvl > 0) ? model_q[0] : '0;
    check("level",     rx_level,             lvl);
    check("not_empty", rx_not_empty,         lvl > 0);
    check("full",      rx_full,              lvl == DEPTH);
    check("afull",     rx_afull,             lvl >= AFULL_LVL);
    check("overflow",  rx_overflow,          model_ovf);
    check("ovf_cnt",   rx_ovf_cnt,           model_cnt);
    check("id_bus",    rxfifo_id2MUX,        exp[127:96]);
    check("dlc_bus",   rxfifo_dlc2MUX,       exp[95:64]);
    check("d1_bus",    rxfifo_dataword12MUX, exp[63:32]);
    check("d2_bus",    rxfifo_dataword22MUX, exp[31:0]);
  endtask

  // Drive one cycle of inputs, advance one edge, then check just after it.
  task automatic step(input bit wr, input logic [127:0] msg, input bit pop,
                      input bit clr, input bit rst);
    rx_wr_en     = wr;
    rx_wr_msg    = msg;
    rx_rd_pop    = pop;
    ovf_clr      = clr;
    IP2Can_reset = rst;
    @(posedge sys_clk);
    model_edge(wr, msg, pop, clr, rst);
    #1;
    compare_all();
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) step(1, mk(i, 8, 32'hA000 + i, 32'hB000 + i), 0, 0, 0);
  endtask

  initial begin
    model_ovf = 0;
    model_cnt = 0;
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);

    // Reset in mid-traffic, overriding a same-cycle push and pop
    fill(3);
    step(1, mk(32'h77, 1, 2, 3), 1, 0, 1);
    check("t1_level", rx_level, 0);
    check("t1_not_empty", rx_not_empty, 0);
    check("t1_id", rxfifo_id2MUX, 0);

    // Single frame into an empty buffer
    step(1, mk(32'h123, 8, 32'hDEADBEEF, 32'hCAFEF00D), 0, 0, 0);
    check("t2_id",  rxfifo_id2MUX,        32'h123);
    check("t2_dlc", rxfifo_dlc2MUX,       32'h8);
    check("t2_d1",  rxfifo_dataword12MUX, 32'hDEADBEEF);
    check("t2_d2",  rxfifo_dataword22MUX, 32'hCAFEF00D);
    check("t2_level", rx_level, 1);
    step(0, '0, 0, 0, 1);

    // Fill to DEPTH, then drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, mk(i, 8, 32'hA000 + i, 32'hB000 + i), 0, 0, 0);
      check("t3_afull", rx_afull, i >= AFULL_LVL);
    end
    check("t3_full", rx_full, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("t3_order", rxfifo_id2MUX, i);
      step(0, '0, 1, 0, 0);
    end
    check("t3_empty_id", rxfifo_id2MUX, 0);

    // Drop on full, then push with pop on full
    fill(DEPTH);
    step(1, mk(9, 8, 9, 9), 0, 0, 0);
    check("t4_ovf", rx_overflow, 1);
    check("t4_cnt", rx_ovf_cnt, 1);
    check("t4_head", rxfifo_id2MUX, 1);
    step(1, mk(9, 8, 9, 9), 1, 0, 0);
    check("t4_level", rx_level, DEPTH);
    check("t4_cnt2", rx_ovf_cnt, 1);
    check("t4_head2", rxfifo_id2MUX, 2);

    // Push and pop together on empty; pop on empty
    step(0, '0, 0, 0, 1);
    step(1, mk(32'h55, 2, 3, 4), 1, 0, 0);
    check("t5_level", rx_level, 1);
    check("t5_id", rxfifo_id2MUX, 32'h55);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    check("t5_underflow", rx_level, 0);

    // Counter saturation, then clear racing a drop
    fill(DEPTH);
    for (int i = 0; i < 300; i++) step(1, mk(i, 0, 0, 0), 0, 0, 0);
    check("t6_sat", rx_ovf_cnt, 255);
    step(1, mk(1, 0, 0, 0), 0, 1, 0);
    check("t6_race_ovf", rx_overflow, 1);
    check("t6_race_cnt", rx_ovf_cnt, 1);
    step(0, '0, 0, 1, 0);
    check("t6_clr", rx_ovf_cnt, 0);

    // Randomized traffic with shifting push/pop bias
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      int wr_pct, pop_pct;
      wr_pct  = ((i / 200) % 2 == 0) ? 75 : 30;
      pop_pct = 100 - wr_pct;
      step($urandom_range(0, 99) < wr_pct,
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 99) < pop_pct,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 999) < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
